pipe_ctrl: RTL and testbench

- Pipeline control and condition-code owner for the Y86-64 five-stage pipeline.
- Detects load/use, ret and branch-mispredict hazards and drives per-stage stall/bubble controls.
- Holds the architectural CC register (ZF/SF/OF) and evaluates jXX/cmovXX conditions for the execute stage.
- Runs a status FSM that drains the pipe on an exception and freezes it once the exception retires.

---
 rtl/y86_pkg.sv | 30 +++
 rtl/pipe_ctrl_cond_eval.sv | 29 ++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: icodes, register/status IDs and the pipe-control FSM states.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_cond_eval.sv
// cond_eval: jXX/cmovXX condition from ifun and the ZF/SF/OF flags.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd
);

  logic lt;
  assign lt = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = lt | zf;
      4'h2:    cnd = lt;
      4'h3:    cnd = zf;
      4'h4:    cnd = ~zf;
      4'h5:    cnd = ~lt;
      4'h6:    cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline hazard control, CC register and exception drain/halt FSM.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl
  import y86_pkg::*;
`ifdef PIPE_PERF_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_ifun,
  input  logic [3:0] E_dstM,
  input  logic [3:0] M_icode,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_of,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       e_cnd,
  output logic       cc_zf,
  output logic       cc_sf,
  output logic       cc_of,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       halted,
  output logic [2:0] halt_stat
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] rt_cnt
`endif
);

  state_e state, state_nxt;
  logic   lu, rt, mp, m_exc, w_exc, set_cc;

  cond_eval u_cond (
    .ifun (E_ifun),
    .zf   (cc_zf),
    .sf   (cc_sf),
    .of   (cc_of),
    .cnd  (e_cnd)
  );

  assign lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign rt = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mp = (E_icode == IJXX) && !e_cnd;

  assign m_exc  = (m_stat != SAOK);
  assign w_exc  = (W_stat != SAOK);
  assign set_cc = (E_icode == IOPQ) && !m_exc && !w_exc && (state == RUN);
  assign halted = (state == HALT);

  // D_stall wins over a ret bubble so the stalled instruction is not lost.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (state == HALT) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end else begin
      F_stall  = lu | rt;
      D_stall  = lu;
      D_bubble = mp | (rt & ~lu);
      E_bubble = mp | lu;
      M_bubble = m_exc | w_exc;
      W_stall  = w_exc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (w_exc) state_nxt = HALT;
               else if (m_exc) state_nxt = DRAIN;
      DRAIN:   if (w_exc) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      halt_stat <= SAOK;
      cc_zf     <= 1'b1;
      cc_sf     <= 1'b0;
      cc_of     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != HALT && w_exc) halt_stat <= W_stat;
      if (set_cc) begin
        cc_zf <= alu_zf;
        cc_sf <= alu_sf;
        cc_of <= alu_of;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic active;
  assign active = (state != HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      lu_cnt  <= '0;
      mp_cnt  <= '0;
      rt_cnt  <= '0;
    end else if (active) begin
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
      if (lu && lu_cnt != '1) lu_cnt <= lu_cnt + 1'b1;
      if (mp && mp_cnt != '1) mp_cnt <= mp_cnt + 1'b1;
      if (rt && !lu && rt_cnt != '1) rt_cnt <= rt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle comparison against a behavioural model plus literal checks.
module tb_pipe_ctrl;
  import y86_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_dstM, M_icode;
  logic       alu_zf, alu_sf, alu_of;
  logic [2:0] m_stat, W_stat;
  logic       e_cnd, cc_zf, cc_sf, cc_of;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [2:0] halt_stat;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt, lu_cnt, mp_cnt, rt_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM), .M_icode(M_icode),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .m_stat(m_stat), .W_stat(W_stat),
    .e_cnd(e_cnd), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .halt_stat(halt_stat)
`ifdef PIPE_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .rt_cnt(rt_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_halt, m_drain;
  logic [2:0] m_hstat;
  logic       m_zf, m_sf, m_of;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halt <= 1'b0; m_drain <= 1'b0; m_hstat <= SAOK;
      m_zf <= 1'b1; m_sf <= 1'b0; m_of <= 1'b0;
    end else if (!m_halt) begin
      if (W_stat != SAOK) begin
        m_halt <= 1'b1; m_hstat <= W_stat;
      end else if (m_stat != SAOK) m_drain <= 1'b1;
      if (E_icode == IOPQ && m_stat == SAOK && W_stat == SAOK && !m_drain) begin
        m_zf <= alu_zf; m_sf <= alu_sf; m_of <= alu_of;
      end
    end
  end

  function automatic logic ref_cnd(input logic [3:0] f, input logic z, input logic s, input logic o);
    logic less;
    less = (s != o);
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || z;
      4'd2: return less;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !less;
      4'd6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic c, lu, rt, mp;
    logic [5:0] ctl;
    if (rst_n) begin
      c  = ref_cnd(E_ifun, m_zf, m_sf, m_of);
      lu = (E_icode == IMRMOVQ || E_icode == IPOPQ) && E_dstM != RNONE &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
      rt = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
      mp = (E_icode == IJXX) && !c;
      if (m_halt) ctl = 6'b110111;
      else ctl = {lu || rt, lu, mp || (rt && !lu), mp || lu,
                  (m_stat != SAOK) || (W_stat != SAOK), W_stat != SAOK};
      chk("cyc_e_cnd", e_cnd, c);
      chk("cyc_cc", {cc_zf, cc_sf, cc_of}, {m_zf, m_sf, m_of});
      chk("cyc_ctrl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, ctl);
      chk("cyc_halted", halted, m_halt);
      chk("cyc_halt_stat", halt_stat, m_hstat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    D_icode = INOP; d_srcA = RNONE; d_srcB = RNONE;
    E_icode = INOP; E_ifun = 4'h0; E_dstM = RNONE; M_icode = INOP;
    alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0;
    m_stat = SAOK; W_stat = SAOK;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    #12;
    chk("rst_halted", halted, 1'b0);
    chk("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("rst_halt_stat", halt_stat, SAOK);
    rst_n = 1'b1;

    cyc(); #2;
    chk("idle_ctrl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, 6'b0);

    // load/use on srcA, then RNONE boundary, then via srcB
    cyc(); E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3; #2;
    chk("lu_a", {F_stall, D_stall, D_bubble, E_bubble}, 4'b1101);
    cyc(); E_icode = IMRMOVQ; #2;
    chk("lu_rnone", {F_stall, D_stall, D_bubble, E_bubble}, 4'b0000);
    cyc(); E_icode = IPOPQ; E_dstM = 4'd4; d_srcB = 4'd4; #2;
    chk("lu_b", {F_stall, D_stall, D_bubble, E_bubble}, 4'b1101);

    // CC update and mispredict
    cyc(); E_icode = IOPQ; alu_sf = 1'b1;
    cyc(); E_icode = IOPQ; alu_zf = 1'b1; #2;
    chk("cc_first", {cc_zf, cc_sf, cc_of}, 3'b010);
    cyc(); E_icode = IJXX; E_ifun = 4'd4; #2;
    chk("mp_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("mp_cnd", e_cnd, 1'b0);
    chk("mp_ctrl", {F_stall, D_bubble, E_bubble}, 3'b011);

    // condition sweep with CC = zf0 sf1 of0
    cyc(); E_icode = IOPQ; alu_sf = 1'b1;
    for (int f = 0; f < 9; f++) begin
      cyc(); E_ifun = f[3:0]; #2;
      case (f)
        1: chk("cnd_le", e_cnd, 1'b1);
        3: chk("cnd_e", e_cnd, 1'b0);
        5: chk("cnd_ge", e_cnd, 1'b0);
        7: chk("cnd_7", e_cnd, 1'b0);
        default: ;
      endcase
    end

    // ret hazards
    cyc(); D_icode = IRET; E_icode = IMRMOVQ; E_dstM = 4'd2; d_srcA = 4'd2; #2;
    chk("rt_lu", {F_stall, D_stall, D_bubble, E_bubble}, 4'b1101);
    cyc(); M_icode = IRET; #2;
    chk("rt_only", {F_stall, D_stall, D_bubble, E_bubble}, 4'b1010);
    cyc(); D_icode = IRET; E_icode = IJXX; E_ifun = 4'd3; #2;
    chk("mp_rt", {F_stall, D_stall, D_bubble, E_bubble}, 4'b1011);

    // exception drain: CC is zf0 sf1 of0 going in
    cyc(); E_icode = IOPQ; alu_zf = 1'b1; alu_of = 1'b1; m_stat = SADR; #2;
    chk("exc_mb", {M_bubble, W_stall}, 2'b10);
    cyc(); E_icode = IOPQ; alu_zf = 1'b1; alu_of = 1'b1; #2;
    chk("exc_cc_blocked", {cc_zf, cc_sf, cc_of}, 3'b010);
    chk("drain_not_halted", halted, 1'b0);
    cyc(); W_stat = SADR; #2;
    chk("drain_cc_frozen", {cc_zf, cc_sf, cc_of}, 3'b010);
    chk("drain_wstall", {M_bubble, W_stall}, 2'b11);
    cyc(); E_icode = IOPQ; alu_zf = 1'b1; #2;
    chk("halt_flag", halted, 1'b1);
    chk("halt_stat", halt_stat, SADR);
    chk("halt_ctrl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, 6'b110111);
    cyc(); #2;
    chk("halt_cc_frozen", {cc_zf, cc_sf, cc_of}, 3'b010);

    // async reset from HALT
    rst_n = 1'b0; #1;
    chk("areset_halted", halted, 1'b0);
    chk("areset_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("areset_stat", halt_stat, SAOK);
    @(negedge clk); #1; rst_n = 1'b1;
    cyc(); E_ifun = 4'd3; #2;
    chk("post_rst_cnd", e_cnd, 1'b1);

    // direct RUN -> HALT
    cyc(); W_stat = SHLT; #2;
    chk("direct_ctrl", {M_bubble, W_stall, halted}, 3'b110);
    cyc(); #2;
    chk("direct_halt", {halted, halt_stat}, {1'b1, SHLT});

`ifdef PIPE_PERF_CNT_EN
    rst_n = 1'b0; #1;
    chk("cnt_rst", mp_cnt + lu_cnt, 32'd0);
    @(negedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); E_icode = IJXX; E_ifun = 4'd4;
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); E_icode = IMRMOVQ; E_dstM = 4'd1; d_srcA = 4'd1;
    end
    cyc(); W_stat = SADR;
    cyc(); E_icode = IJXX; E_ifun = 4'd4;
    cyc(); #2;
    chk("mp_cnt", mp_cnt, 32'd3);
    chk("lu_cnt", lu_cnt, 32'd2);
`endif

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
